// File: rtl/dff_bank_pkg.sv
// dff_bank_pkg
//   Shared types and constants for the DFF bank arbiter slice.
//   state_t   : arbiter FSM states
//   HOLD_CW   : width of the cool-down counter (covers 0..15 idle cycles)
//   calc_aw() : register-bank address width for a given depth
package dff_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  localparam int HOLD_CW = 4;

  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// dff_bank_arbiter_if
//   Write-side handshake between the requesting control blocks and the arbiter.
//   req   : one level request bit per requester
//   addr  : per-requester target register, slice i = [i*AW +: AW]
//   wdata : per-requester write data, slice i = [i*WIDTH +: WIDTH]
//   gnt   : one-hot grant, one cycle per write
//   done  : one-cycle pulse when the write is committed
//   busy  : arbiter is not idle
//   master modport = requester side, slave modport = arbiter side.
interface dff_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import dff_bank_pkg::*;

  localparam int AW = calc_aw(DEPTH);

  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic                  busy;

  modport master (output req, addr, wdata, input gnt, done, busy);
  modport slave  (input req, addr, wdata, output gnt, done, busy);

endinterface

// File: rtl/dff_word.sv
// dff_word
//   One WIDTH-bit register of the shared bank.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear
//   we    : load enable
//   d     : data to load
//   q     : register contents
module dff_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
//   Round-robin arbiter sharing a DEPTH x WIDTH register bank among NREQ
//   writers: one write per grant, followed by HOLD_CYC forced idle cycles.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : write handshake (req/addr/wdata in, gnt/done/busy out)
//   rd_addr : free-running read select
//   rd_data : bank[rd_addr], straight from the register outputs
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 4,
  parameter  int HOLD_CYC = 2,
  localparam int AW       = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  dff_bank_arbiter_if.slave bus,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t               state;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        win_q;
  logic [NREQ-1:0]      gnt_q;
  logic                 done_q;
  logic                 busy_q;
  logic [HOLD_CW-1:0]   cnt_q;

  logic [PW-1:0]        pick;
  logic [PW-1:0]        scan_idx;
  logic                 found;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic [DEPTH-1:0]     we;
  logic [WIDTH-1:0]     bank_q [DEPTH];

  // Masked priority encoder: first asserted request scanning from the
  // round-robin pointer upward, wrapping at NREQ.
  always_comb begin
    pick     = ptr_q;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.req[scan_idx]) begin
        pick  = scan_idx;
        found = 1'b1;
      end
    end
  end

  // Address/data of the latched winner are taken live, so the write uses
  // whatever the winner presents at the closing edge of GRANT.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_q == PW'(i)) begin
        wr_addr = bus.addr[i*AW +: AW];
        wr_data = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    we = '0;
    for (int g = 0; g < DEPTH; g++) begin
      we[g] = (state == GRANT) && (wr_addr == AW'(g));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_bank
    dff_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[g]),
      .d     (wr_data),
      .q     (bank_q[g])
    );
  end

  assign rd_data = bank_q[rd_addr];

  // Arbiter FSM; gnt/done/busy are registered alongside the state so they
  // line up exactly with the GRANT cycle and the cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr_q  <= '0;
      win_q  <= '0;
      gnt_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            win_q  <= pick;
            gnt_q  <= NREQ'(1) << pick;
            busy_q <= 1'b1;
            state  <= GRANT;
          end
        end
        GRANT: begin
          gnt_q  <= '0;
          done_q <= 1'b1;
          ptr_q  <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
          cnt_q  <= '0;
          if (HOLD_CYC > 0) begin
            state <= COOL;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        COOL: begin
          if (cnt_q == HOLD_CW'(HOLD_CYC - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + HOLD_CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          gnt_q  <= '0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter
//   Self-checking bench for dff_bank_arbiter. Two instances share clock and
//   reset: dut2 with HOLD_CYC=2 and dut0 with HOLD_CYC=0.
module tb_dff_bank_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] rd_addr2;
  logic [1:0] rd_addr0;
  logic [7:0] rd_data2;
  logic [7:0] rd_data0;
  int         checks;
  int         errors;

  dff_bank_arbiter_if #(.NREQ(4), .WIDTH(8), .DEPTH(4)) bus2 ();
  dff_bank_arbiter_if #(.NREQ(4), .WIDTH(8), .DEPTH(4)) bus0 ();

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(4), .HOLD_CYC(2)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus2.slave),
    .rd_addr (rd_addr2),
    .rd_data (rd_data2)
  );

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(4), .HOLD_CYC(0)) dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus0.slave),
    .rd_addr (rd_addr0),
    .rd_data (rd_data0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First asserted request scanning p, p+1, ... wrapping at 4.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n      = 1'b0;
    bus2.req   = '0;
    bus2.addr  = '0;
    bus2.wdata = '0;
    bus0.req   = '0;
    bus0.addr  = '0;
    bus0.wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle2();
    int n;
    n = 0;
    while (bus2.busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus2.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle2_timeout: busy=%b required 0", bus2.busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus2.gnt !== 4'b0 || bus2.done !== 1'b0 || bus2.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: gnt=%b done=%b busy=%b required 0/0/0",
               bus2.gnt, bus2.done, bus2.busy);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr2 = 2'(i);
      #1;
      checks++;
      if (rd_data2 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_read%0d: got %h required 00", i, rd_data2);
      end
    end
    // idle with no requests
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus2.gnt !== 4'b0 || bus2.done !== 1'b0 || bus2.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_quiet: gnt=%b done=%b busy=%b required 0/0/0",
                 bus2.gnt, bus2.done, bus2.busy);
      end
    end
    // write addr 3, then pulse reset during the cool-down
    rd_addr2   = 2'd3;
    bus2.addr  = 8'b0000_0011;
    bus2.wdata = 32'h0000_00C3;
    bus2.req   = 4'b0001;
    @(negedge clk);
    bus2.req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus2.busy !== 1'b1 || rd_data2 !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL cool_before_reset: busy=%b rd=%h required 1/c3", bus2.busy, rd_data2);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus2.gnt !== 4'b0 || bus2.done !== 1'b0 || bus2.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_cool: gnt=%b done=%b busy=%b required 0/0/0",
               bus2.gnt, bus2.done, bus2.busy);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr2 = 2'(i);
      #1;
      checks++;
      if (rd_data2 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_clear%0d: got %h required 00", i, rd_data2);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    apply_reset();
    rd_addr2   = 2'd2;
    bus2.addr  = 8'b0010_0000;
    bus2.wdata = 32'h00A5_0000;
    bus2.req   = 4'b0100;
    @(negedge clk);
    checks++;
    if (bus2.gnt !== 4'b0100 || bus2.done !== 1'b0 || bus2.busy !== 1'b1 || rd_data2 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL single_grant: gnt=%b done=%b busy=%b rd=%h required 0100/0/1/00",
               bus2.gnt, bus2.done, bus2.busy, rd_data2);
    end
    bus2.req = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus2.gnt !== 4'b0000 || bus2.done !== 1'b1 || rd_data2 !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_done: gnt=%b done=%b rd=%h required 0000/1/a5",
               bus2.gnt, bus2.done, rd_data2);
    end
    wait_idle2();
  endtask

  task automatic test_round_robin();
    int gcyc[5];
    logic [3:0] gval[5];
    int n;
    apply_reset();
    n          = 0;
    bus2.addr  = 8'b11_10_01_00;
    bus2.wdata = 32'h4433_2211;
    bus2.req   = 4'b1111;
    for (int c = 0; c < 30 && n < 5; c++) begin
      @(negedge clk);
      checks++;
      if (!$onehot0(bus2.gnt)) begin
        errors++;
        $display("[TB] FAIL rr_onehot: gnt=%b required at most one bit", bus2.gnt);
      end
      if (bus2.gnt !== 4'b0) begin
        gcyc[n] = c;
        gval[n] = bus2.gnt;
        n++;
      end
    end
    bus2.req = 4'b0000;
    checks++;
    if (n != 5) begin
      errors++;
      $display("[TB] FAIL rr_count: got %0d grants required 5", n);
    end else begin
      checks++;
      if (gcyc[0] != 0) begin
        errors++;
        $display("[TB] FAIL rr_latency: first grant at %0d required 0", gcyc[0]);
      end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gval[k] !== 4'(1 << (k % 4))) begin
          errors++;
          $display("[TB] FAIL rr_order%0d: gnt=%b required %b", k, gval[k], 4'(1 << (k % 4)));
        end
        if (k > 0) begin
          checks++;
          if (gcyc[k] - gcyc[k-1] != 4) begin
            errors++;
            $display("[TB] FAIL rr_spacing%0d: got %0d cycles required 4", k, gcyc[k] - gcyc[k-1]);
          end
        end
      end
    end
    wait_idle2();
    for (int i = 0; i < 4; i++) begin
      rd_addr2 = 2'(i);
      #1;
      checks++;
      if (rd_data2 !== 8'(8'h11 * (i + 1))) begin
        errors++;
        $display("[TB] FAIL rr_bank%0d: got %h required %h", i, rd_data2, 8'(8'h11 * (i + 1)));
      end
    end
  endtask

  task automatic test_pointer_wrap();
    logic [3:0] seen[2];
    int n;
    apply_reset();
    n          = 0;
    bus2.addr  = 8'b0000_0000;
    bus2.wdata = 32'h3300_0030;
    bus2.req   = 4'b1000;
    @(negedge clk);
    checks++;
    if (bus2.gnt !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL wrap_first: gnt=%b required 1000", bus2.gnt);
    end
    bus2.req = 4'b0000;
    @(negedge clk);
    wait_idle2();
    bus2.req = 4'b1001;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (bus2.gnt !== 4'b0) begin
        seen[n] = bus2.gnt;
        n++;
        bus2.req = bus2.req & ~bus2.gnt;
      end
    end
    bus2.req = 4'b0000;
    checks++;
    if (n != 2 || seen[0] !== 4'b0001 || seen[1] !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL wrap_order: n=%0d first=%b second=%b required 2/0001/1000",
               n, seen[0], seen[1]);
    end
    wait_idle2();
  endtask

  task automatic test_collision();
    int ndone;
    apply_reset();
    ndone      = 0;
    rd_addr2   = 2'd1;
    bus2.addr  = 8'b0000_0101;
    bus2.wdata = 32'h0000_2211;
    bus2.req   = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus2.done === 1'b1) begin
        ndone++;
        checks++;
        if (rd_data2 !== ((ndone == 1) ? 8'h11 : 8'h22)) begin
          errors++;
          $display("[TB] FAIL collide_step%0d: rd=%h required %h", ndone, rd_data2,
                   (ndone == 1) ? 8'h11 : 8'h22);
        end
      end
      bus2.req = bus2.req & ~bus2.gnt;
    end
    checks++;
    if (ndone != 2 || rd_data2 !== 8'h22) begin
      errors++;
      $display("[TB] FAIL collide_final: done pulses=%0d rd=%h required 2/22", ndone, rd_data2);
    end
  endtask

  // Timeline reference model: a request seen while the arbiter is free
  // produces a grant next cycle, a done the cycle after, and frees the
  // arbiter 2+HOLD cycles after the request cycle.
  task automatic test_random();
    logic [7:0]  m_bank[4];
    int          m_ptr, m_win, m_gcyc, m_free;
    logic [3:0]  exp_gnt, r;
    logic [7:0]  a;
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < 4; i++) m_bank[i] = 8'h00;
    m_ptr  = 0;
    m_win  = 0;
    m_gcyc = -10;
    m_free = 0;
    for (int t = 0; t < 300; t++) begin
      exp_gnt = (t == m_gcyc) ? 4'(1 << m_win) : 4'b0;
      checks++;
      if (bus2.gnt !== exp_gnt || bus2.done !== (t == m_gcyc + 1) ||
          bus2.busy !== (t >= m_gcyc && t < m_free) || rd_data2 !== m_bank[rd_addr2]) begin
        errors++;
        $display("[TB] FAIL rand_c%0d: gnt=%b done=%b busy=%b rd=%h required %b/%b/%b/%h",
                 t, bus2.gnt, bus2.done, bus2.busy, rd_data2, exp_gnt, (t == m_gcyc + 1),
                 (t >= m_gcyc && t < m_free), m_bank[rd_addr2]);
      end
      r = bus2.req;
      a = bus2.addr;
      d = bus2.wdata;
      for (int i = 0; i < 4; i++) begin
        if (!r[i] || exp_gnt[i]) begin
          r[i]         = ($urandom_range(0, 3) != 0);
          a[i*2 +: 2]  = 2'($urandom_range(0, 3));
          d[i*8 +: 8]  = 8'($urandom);
        end
      end
      bus2.req   = r;
      bus2.addr  = a;
      bus2.wdata = d;
      rd_addr2   = 2'($urandom_range(0, 3));
      if (t == m_gcyc) begin
        m_bank[a[m_win*2 +: 2]] = d[m_win*8 +: 8];
        m_ptr = (m_win + 1) % 4;
      end
      if (t >= m_free && r != 4'b0) begin
        m_win  = rr_pick(r, m_ptr);
        m_gcyc = t + 1;
        m_free = t + 4;
      end
      @(negedge clk);
    end
    bus2.req = 4'b0000;
  endtask

  task automatic test_hold_zero();
    int gcyc[5];
    logic [3:0] gval[5];
    int n;
    apply_reset();
    n          = 0;
    bus0.addr  = 8'b0000_0100;
    bus0.wdata = 32'h0000_BBAA;
    bus0.req   = 4'b0011;
    for (int c = 0; c < 20 && n < 5; c++) begin
      @(negedge clk);
      if (bus0.gnt !== 4'b0) begin
        gcyc[n] = c;
        gval[n] = bus0.gnt;
        n++;
      end
    end
    bus0.req = 4'b0000;
    checks++;
    if (n != 5) begin
      errors++;
      $display("[TB] FAIL h0_count: got %0d grants required 5", n);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gval[k] !== ((k % 2 == 0) ? 4'b0001 : 4'b0010) ||
            (k > 0 && gcyc[k] - gcyc[k-1] != 2)) begin
          errors++;
          $display("[TB] FAIL h0_alt%0d: gnt=%b cycle=%0d required %b every 2 cycles",
                   k, gval[k], gcyc[k], (k % 2 == 0) ? 4'b0001 : 4'b0010);
        end
      end
    end
    repeat (3) @(negedge clk);
    // reset while in GRANT: the write must be lost
    rd_addr0   = 2'd2;
    bus0.addr  = 8'b0000_0010;
    bus0.wdata = 32'h0000_005A;
    bus0.req   = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus0.gnt !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL h0_grant_before_reset: gnt=%b required 0001", bus0.gnt);
    end
    #1 rst_n = 1'b0;
    bus0.req = 4'b0000;
    #1;
    checks++;
    if (bus0.gnt !== 4'b0 || bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL h0_reset_in_grant: gnt=%b done=%b busy=%b required 0/0/0",
               bus0.gnt, bus0.done, bus0.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus0.done !== 1'b0 || rd_data0 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL h0_lost_write%0d: done=%b rd=%h required 0/00", c, bus0.done, rd_data0);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rd_addr2 = 2'd0;
    rd_addr0 = 2'd0;
    apply_reset();
    test_reset();
    test_single_write();
    test_round_robin();
    test_pointer_wrap();
    test_collision();
    test_random();
    test_hold_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
